// File: rtl/mem_access_stage.sv
// LEGv8 memory-access stage: multi-cycle data-memory load/store, PCSrc resolution, valid/ready handoff.
// Optional alignment fault detection is compiled in by defining MISALIGN_CHECK_EN.
`ifndef WORD
`define WORD 64
`endif

module mem_access_stage #(
    parameter int unsigned WORD        = `WORD,
    parameter int unsigned DEPTH_LOG2  = 6,
    parameter int          MEM_LATENCY = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WORD-1:0] alu_result,
    input  logic [WORD-1:0] write_data,
    input  logic [WORD-1:0] branch_target,
    input  logic            zero,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            branch,
    input  logic            uncond_branch,
    output logic            out_valid,
    output logic [WORD-1:0] read_data,
    output logic [WORD-1:0] alu_result_out,
    output logic [WORD-1:0] branch_target_out,
    output logic            pc_src,
    output logic            misaligned
);

    localparam int unsigned DEPTH = 32'd1 << DEPTH_LOG2;
    localparam int          LAT   = (MEM_LATENCY < 1) ? 1 : MEM_LATENCY;
    localparam int unsigned CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [WORD-1:0]       addr_q, addr_d;
    logic [WORD-1:0]       wdata_q, wdata_d;
    logic [WORD-1:0]       target_q, target_d;
    logic                  rd_q, rd_d, wr_q, wr_d;
    logic                  br_q, br_d, ub_q, ub_d, zero_q, zero_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [WORD-1:0]       read_data_q, read_data_d;
    logic [WORD-1:0]       alu_result_out_q, alu_result_out_d;
    logic [WORD-1:0]       branch_target_out_q, branch_target_out_d;
    logic                  pc_src_q, pc_src_d;
    logic                  mem_we_c;
    logic                  mis_c;
    logic [DEPTH_LOG2-1:0] idx_c;
    logic [WORD-1:0]       mem_q [DEPTH];

    assign idx_c = addr_q[DEPTH_LOG2+2:3];

`ifdef MISALIGN_CHECK_EN
    logic misaligned_q, misaligned_d;
    assign mis_c      = (mem_read || mem_write) && (alu_result[2:0] != 3'b000);
    assign misaligned = misaligned_q;
`else
    assign mis_c      = 1'b0;
    assign misaligned = 1'b0;
`endif

    // Next-state and registered-output logic; results are loaded on entry to RESP.
    always_comb begin
        state_d             = state_q;
        cnt_d               = cnt_q;
        addr_d              = addr_q;
        wdata_d             = wdata_q;
        target_d            = target_q;
        rd_d                = rd_q;
        wr_d                = wr_q;
        br_d                = br_q;
        ub_d                = ub_q;
        zero_d              = zero_q;
        read_data_d         = read_data_q;
        alu_result_out_d    = alu_result_out_q;
        branch_target_out_d = branch_target_out_q;
        pc_src_d            = pc_src_q;
        mem_we_c            = 1'b0;
`ifdef MISALIGN_CHECK_EN
        misaligned_d        = misaligned_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    addr_d   = alu_result;
                    wdata_d  = write_data;
                    target_d = branch_target;
                    rd_d     = mem_read;
                    wr_d     = mem_write;
                    br_d     = branch;
                    ub_d     = uncond_branch;
                    zero_d   = zero;
`ifdef MISALIGN_CHECK_EN
                    misaligned_d = mis_c;
`endif
                    if ((mem_read || mem_write) && !mis_c) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(LAT - 1);
                    end else begin
                        // Non-memory or faulted op: results come straight from the inputs.
                        state_d             = S_RESP;
                        read_data_d         = '0;
                        alu_result_out_d    = alu_result;
                        branch_target_out_d = branch_target;
                        pc_src_d            = uncond_branch | (branch & zero);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d             = S_RESP;
                    mem_we_c            = wr_q;
                    read_data_d         = (rd_q && !wr_q) ? mem_q[idx_c] : '0;
                    alu_result_out_d    = addr_q;
                    branch_target_out_d = target_q;
                    pc_src_d            = ub_q | (br_q & zero_q);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q             <= S_IDLE;
            cnt_q               <= '0;
            addr_q              <= '0;
            wdata_q             <= '0;
            target_q            <= '0;
            rd_q                <= 1'b0;
            wr_q                <= 1'b0;
            br_q                <= 1'b0;
            ub_q                <= 1'b0;
            zero_q              <= 1'b0;
            in_ready_q          <= 1'b1;
            out_valid_q         <= 1'b0;
            read_data_q         <= '0;
            alu_result_out_q    <= '0;
            branch_target_out_q <= '0;
            pc_src_q            <= 1'b0;
`ifdef MISALIGN_CHECK_EN
            misaligned_q        <= 1'b0;
`endif
        end else begin
            state_q             <= state_d;
            cnt_q               <= cnt_d;
            addr_q              <= addr_d;
            wdata_q             <= wdata_d;
            target_q            <= target_d;
            rd_q                <= rd_d;
            wr_q                <= wr_d;
            br_q                <= br_d;
            ub_q                <= ub_d;
            zero_q              <= zero_d;
            in_ready_q          <= in_ready_d;
            out_valid_q         <= out_valid_d;
            read_data_q         <= read_data_d;
            alu_result_out_q    <= alu_result_out_d;
            branch_target_out_q <= branch_target_out_d;
            pc_src_q            <= pc_src_d;
`ifdef MISALIGN_CHECK_EN
            misaligned_q        <= misaligned_d;
`endif
        end
    end

    // Data memory has no reset; a reset during WAIT forces IDLE so the write never fires.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[idx_c] <= wdata_q;
        end
    end

    assign in_ready          = in_ready_q;
    assign out_valid         = out_valid_q;
    assign read_data         = read_data_q;
    assign alu_result_out    = alu_result_out_q;
    assign branch_target_out = branch_target_out_q;
    assign pc_src            = pc_src_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed, table-driven bench for mem_access_stage (DEPTH_LOG2=6, MEM_LATENCY=2).
// Expectations follow MISALIGN_CHECK_EN when it is defined for the build.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] alu_result = '0;
    logic [63:0] write_data = '0;
    logic [63:0] branch_target = '0;
    logic        zero = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        branch = 1'b0;
    logic        uncond_branch = 1'b0;
    logic        out_valid;
    logic [63:0] read_data;
    logic [63:0] alu_result_out;
    logic [63:0] branch_target_out;
    logic        pc_src;
    logic        misaligned;

    int total = 0;
    int bad   = 0;

    mem_access_stage #(.WORD(64), .DEPTH_LOG2(6), .MEM_LATENCY(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .write_data(write_data), .branch_target(branch_target),
        .zero(zero), .mem_read(mem_read), .mem_write(mem_write),
        .branch(branch), .uncond_branch(uncond_branch),
        .out_valid(out_valid), .read_data(read_data), .alu_result_out(alu_result_out),
        .branch_target_out(branch_target_out), .pc_src(pc_src), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr, br, ub, z;
        logic [63:0] addr, wdata, tgt;
        int          lat;
        logic [63:0] rdata;
        logic        pc, mis;
    } vec_t;

    function automatic vec_t mk(input logic rd, input logic wr, input logic br, input logic ub,
                                input logic z, input logic [63:0] addr, input logic [63:0] wdata,
                                input logic [63:0] tgt, input int lat, input logic [63:0] rdata,
                                input logic pc, input logic mis);
        vec_t v;
        v.rd = rd; v.wr = wr; v.br = br; v.ub = ub; v.z = z;
        v.addr = addr; v.wdata = wdata; v.tgt = tgt;
        v.lat = lat; v.rdata = rdata; v.pc = pc; v.mis = mis;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, exp);
        end
    endtask

    // Issue one op from IDLE, measure edges from accept to out_valid, capture the result.
    task automatic run_op(input vec_t v, output int lat, output logic [63:0] rdata,
                          output logic pc, output logic [63:0] alu_o,
                          output logic [63:0] bt_o, output logic mis);
        @(negedge clk);
        mem_read = v.rd; mem_write = v.wr; branch = v.br; uncond_branch = v.ub;
        zero = v.z; alu_result = v.addr; write_data = v.wdata; branch_target = v.tgt;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = read_data; pc = pc_src; alu_o = alu_result_out;
        bt_o = branch_target_out; mis = misaligned;
        @(posedge clk); #1;
    endtask

    vec_t        vecs[$];
    vec_t        v;
    int          lat;
    logic [63:0] r_rd, r_alu, r_bt, alu_first, alu_second;
    logic        r_pc, r_mis;
    logic [5:0]  rdy_seq, ov_seq;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_wide_outs", read_data | alu_result_out | branch_target_out, 64'd0);
        check("rst_flags", 64'({pc_src, misaligned}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Store 0x2222 to 0x08, then abort a store of 0x1111 to 0x08 mid-WAIT
        run_op(mk(0, 1, 0, 0, 0, 64'h08, 64'h2222, 64'h0, 3, 64'h0, 0, 0),
               lat, r_rd, r_pc, r_alu, r_bt, r_mis);
        check("store08_lat", 64'(lat), 64'd3);
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b1; alu_result = 64'h08; write_data = 64'h1111;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("midwait_busy", 64'(in_ready), 64'd0);
        reset_n = 1'b0;
        #1;
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_alu_out", alu_result_out, 64'd0);
        check("abort_flags", 64'({pc_src, misaligned}), 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_op(mk(1, 0, 0, 0, 0, 64'h08, 64'h0, 64'h0, 3, 64'h0, 0, 0),
               lat, r_rd, r_pc, r_alu, r_bt, r_mis);
        check("raw_after_abort_lat", 64'(lat), 64'd3);
        check("raw_after_abort_data", r_rd, 64'h2222);

        // Directed vectors: rd wr br ub z addr wdata tgt | lat rdata pc mis
        vecs.push_back(mk(0, 1, 0, 0, 0, 64'h18, 64'hDEADBEEF_CAFEF00D, 64'h0, 3, 64'h0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 64'h18, 64'h0, 64'h0, 3, 64'hDEADBEEF_CAFEF00D, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 64'h05, 64'h0, 64'h40, 1, 64'h0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 64'h05, 64'h0, 64'h40, 1, 64'h0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 64'h07, 64'h0, 64'h80, 1, 64'h0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 64'h200, 64'hABCD, 64'h0, 3, 64'h0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 64'h000, 64'h0, 64'h0, 3, 64'hABCD, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 64'h30, 64'h5555, 64'h0, 3, 64'h0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 64'h30, 64'h0, 64'h0, 3, 64'h5555, 0, 0));
`ifdef MISALIGN_CHECK_EN
        vecs.push_back(mk(0, 1, 0, 0, 0, 64'h1C, 64'h7777, 64'h0, 1, 64'h0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 64'h18, 64'h0, 64'h0, 3, 64'hDEADBEEF_CAFEF00D, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 64'h1F, 64'h0, 64'h24, 1, 64'h0, 1, 1));
`else
        vecs.push_back(mk(0, 1, 0, 0, 0, 64'h1C, 64'h7777, 64'h0, 3, 64'h0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 64'h18, 64'h0, 64'h0, 3, 64'h7777, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 64'h1F, 64'h0, 64'h24, 3, 64'h7777, 1, 0));
`endif
        vecs.push_back(mk(0, 0, 0, 0, 1, 64'h1234, 64'h0, 64'h0, 1, 64'h0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 64'h000, 64'h0, 64'h60, 3, 64'hABCD, 1, 0));

        foreach (vecs[i]) begin
            v = vecs[i];
            run_op(v, lat, r_rd, r_pc, r_alu, r_bt, r_mis);
            check($sformatf("v%0d_lat", i), 64'(lat), 64'(v.lat));
            check($sformatf("v%0d_read_data", i), r_rd, v.rdata);
            check($sformatf("v%0d_pc_src", i), 64'(r_pc), 64'(v.pc));
            check($sformatf("v%0d_alu_out", i), r_alu, v.addr);
            check($sformatf("v%0d_bt_out", i), r_bt, v.tgt);
            check($sformatf("v%0d_misaligned", i), 64'(r_mis), 64'(v.mis));
        end

        // Backpressure: in_valid held high across a load; input changes while busy are ignored
        @(negedge clk);
        mem_read = 1'b1; mem_write = 1'b0; branch = 1'b0; uncond_branch = 1'b0;
        alu_result = 64'h18; in_valid = 1'b1;
        @(posedge clk); #1;
        mem_read = 1'b0; alu_result = 64'h99;
        rdy_seq = '0; ov_seq = '0; alu_first = '0; alu_second = '0;
        for (int i = 0; i < 6; i++) begin
            rdy_seq[i] = in_ready;
            ov_seq[i]  = out_valid;
            if (i == 2) alu_first = alu_result_out;
            if (i == 4) begin
                alu_second = alu_result_out;
                in_valid   = 1'b0;
            end
            @(posedge clk); #1;
        end
        check("bp_in_ready_seq", 64'(rdy_seq), 64'(6'b101000));
        check("bp_out_valid_seq", 64'(ov_seq), 64'(6'b010100));
        check("bp_first_alu_out", alu_first, 64'h18);
        check("bp_second_alu_out", alu_second, 64'h99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
